// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, ALU op
// codes, opcode/funct values, instruction classes and datapath select values.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE = 3'd0,
        C_ALUI  = 3'd1,
        C_LW    = 3'd2,
        C_SW    = 3'd3,
        C_BEQ   = 3'd4,
        C_J     = 3'd5,
        C_JAL   = 3'd6,
        C_ILL   = 3'd7
    } iclass_t;

    // ALU operation codes
    localparam logic [3:0] ALU_ADDU  = 4'd0;
    localparam logic [3:0] ALU_SUBU  = 4'd1;
    localparam logic [3:0] ALU_ORI   = 4'd2;
    localparam logic [3:0] ALU_ADD   = 4'd3;
    localparam logic [3:0] ALU_SUB   = 4'd4;
    localparam logic [3:0] ALU_AND   = 4'd5;
    localparam logic [3:0] ALU_OR    = 4'd6;
    localparam logic [3:0] ALU_XOR   = 4'd7;
    localparam logic [3:0] ALU_NOR   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_ADDI  = 4'd11;
    localparam logic [3:0] ALU_ADDIU = 4'd12;
    localparam logic [3:0] ALU_ANDI  = 4'd13;
    localparam logic [3:0] ALU_XORI  = 4'd14;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R     = 6'b00_0000;
    localparam logic [5:0] OP_LW    = 6'b10_0011;
    localparam logic [5:0] OP_SW    = 6'b10_1011;
    localparam logic [5:0] OP_BEQ   = 6'b00_0100;
    localparam logic [5:0] OP_J     = 6'b00_0010;
    localparam logic [5:0] OP_JAL   = 6'b00_0011;
    localparam logic [5:0] OP_ADDI  = 6'b00_1000;
    localparam logic [5:0] OP_ADDIU = 6'b00_1001;
    localparam logic [5:0] OP_ANDI  = 6'b00_1100;
    localparam logic [5:0] OP_ORI   = 6'b00_1101;
    localparam logic [5:0] OP_XORI  = 6'b00_1110;

    // Funct codes (IR[5:0]) for R-type
    localparam logic [5:0] F_ADD  = 6'b10_0000;
    localparam logic [5:0] F_ADDU = 6'b10_0001;
    localparam logic [5:0] F_SUB  = 6'b10_0010;
    localparam logic [5:0] F_SUBU = 6'b10_0011;
    localparam logic [5:0] F_AND  = 6'b10_0100;
    localparam logic [5:0] F_OR   = 6'b10_0101;
    localparam logic [5:0] F_XOR  = 6'b10_0110;
    localparam logic [5:0] F_NOR  = 6'b10_0111;
    localparam logic [5:0] F_SLT  = 6'b10_1010;
    localparam logic [5:0] F_SLTU = 6'b10_1011;

    // Datapath select values
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: op/funct to instruction class plus the
// ALU op and operand-B select used in the execute cycle.
module ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] iclass,
    output logic [3:0] exe_alu_op,
    output logic [1:0] exe_src_b,
    output logic       illegal
);

    always_comb begin
        iclass     = C_ILL;
        exe_alu_op = ALU_ADDU;
        exe_src_b  = SRCB_RT;
        case (op)
            OP_R: begin
                iclass = C_RTYPE;
                case (funct)
                    F_ADD:   exe_alu_op = ALU_ADD;
                    F_ADDU:  exe_alu_op = ALU_ADDU;
                    F_SUB:   exe_alu_op = ALU_SUB;
                    F_SUBU:  exe_alu_op = ALU_SUBU;
                    F_AND:   exe_alu_op = ALU_AND;
                    F_OR:    exe_alu_op = ALU_OR;
                    F_XOR:   exe_alu_op = ALU_XOR;
                    F_NOR:   exe_alu_op = ALU_NOR;
                    F_SLT:   exe_alu_op = ALU_SLT;
                    F_SLTU:  exe_alu_op = ALU_SLTU;
                    default: iclass = C_ILL;
                endcase
            end
            OP_ADDI: begin
                iclass     = C_ALUI;
                exe_src_b  = SRCB_SEXT;
                exe_alu_op = ALU_ADDI;
            end
            OP_ADDIU: begin
                iclass     = C_ALUI;
                exe_src_b  = SRCB_SEXT;
                exe_alu_op = ALU_ADDIU;
            end
            // Logical immediates are zero-extended, unlike addi/addiu.
            OP_ANDI: begin
                iclass     = C_ALUI;
                exe_src_b  = SRCB_ZEXT;
                exe_alu_op = ALU_AND;
            end
            OP_ORI: begin
                iclass     = C_ALUI;
                exe_src_b  = SRCB_ZEXT;
                exe_alu_op = ALU_ORI;
            end
            OP_XORI: begin
                iclass     = C_ALUI;
                exe_src_b  = SRCB_ZEXT;
                exe_alu_op = ALU_XOR;
            end
            OP_LW: begin
                iclass    = C_LW;
                exe_src_b = SRCB_SEXT;
            end
            OP_SW: begin
                iclass    = C_SW;
                exe_src_b = SRCB_SEXT;
            end
            OP_BEQ: begin
                iclass     = C_BEQ;
                exe_alu_op = ALU_SUBU;
            end
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILL;
        endcase
        illegal = (iclass == C_ILL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: five-state FSM driving ALU selects and all
// datapath write enables, with a req/rdy handshake to a single memory port.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zf,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       mem_wr,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] npc_op,
    output logic       illegal,
    output logic [2:0] state
);

    state_t     cur, nxt;
    logic [2:0] dec_class;
    logic [3:0] dec_alu_op;
    logic [1:0] dec_src_b;
    logic       dec_illegal;
    iclass_t    cls;

    ctrl_decode u_decode (
        .op         (op),
        .funct      (funct),
        .iclass     (dec_class),
        .exe_alu_op (dec_alu_op),
        .exe_src_b  (dec_src_b),
        .illegal    (dec_illegal)
    );

    assign cls   = iclass_t'(dec_class);
    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) cur <= S_IF;
        else     cur <= nxt;
    end

    // Memory handshake: mem_req (with mem_wr) is held steady until the cycle
    // mem_rdy=1; that cycle completes the transfer and is the only cycle in
    // which writes gated by mem_rdy fire.
    always_comb begin
        nxt       = cur;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_ADDU;
        reg_dst   = RDST_RT;
        wd_sel    = WD_ALU;
        npc_op    = NPC_PC4;
        illegal   = 1'b0;
        case (cur)
            S_IF: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_4;
                ir_wr     = mem_rdy;
                pc_wr     = mem_rdy;
                if (mem_rdy) nxt = S_ID;
            end
            S_ID: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                    nxt     = S_IF;
                end else if (cls == C_J || cls == C_JAL) begin
                    pc_wr  = 1'b1;
                    npc_op = NPC_J;
                    if (cls == C_JAL) begin
                        reg_wr  = 1'b1;
                        reg_dst = RDST_RA;
                        wd_sel  = WD_PC4;
                    end
                    nxt = S_IF;
                end else begin
                    nxt = S_EXE;
                end
            end
            S_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = dec_src_b;
                alu_op    = dec_alu_op;
                case (cls)
                    C_LW, C_SW: nxt = S_MEM;
                    C_BEQ: begin
                        pc_wr  = zf;
                        npc_op = NPC_BR;
                        nxt    = S_IF;
                    end
                    default: nxt = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_wr  = (cls == C_SW);
                if (mem_rdy) nxt = (cls == C_SW) ? S_IF : S_WB;
            end
            S_WB: begin
                reg_wr = 1'b1;
                if (cls == C_RTYPE) reg_dst = RDST_RD;
                if (cls == C_LW)    wd_sel  = WD_MDR;
                nxt = S_IF;
            end
            default: nxt = S_IF;
        endcase
        // Reset aborts the instruction immediately: no write or request leaks out.
        if (rst) begin
            mem_req = 1'b0;
            mem_wr  = 1'b0;
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            reg_wr  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each step drives inputs for one cycle and checks
// the full output vector against hand-computed values.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zf;
    logic       mem_rdy;
    logic       mem_req;
    logic       mem_wr;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] npc_op;
    logic       illegal;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    mc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .zf        (zf),
        .mem_rdy   (mem_rdy),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .pc_wr     (pc_wr),
        .ir_wr     (ir_wr),
        .reg_wr    (reg_wr),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .npc_op    (npc_op),
        .illegal   (illegal),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed layout: state, mem_req, mem_wr, pc_wr, ir_wr, reg_wr, alu_src_a,
    // alu_src_b, alu_op, reg_dst, wd_sel, npc_op, illegal.
    function automatic logic [21:0] o(int st, int mreq, int mwr, int pcw, int irw,
                                      int rw, int sa, int sb, int aop, int rdst,
                                      int wd, int npc, int ill);
        return {st[2:0], mreq[0], mwr[0], pcw[0], irw[0], rw[0], sa[0],
                sb[1:0], aop[3:0], rdst[1:0], wd[1:0], npc[1:0], ill[0]};
    endfunction

    function automatic logic [21:0] f_if(int rdy);
        return o(0, 1, 0, rdy, rdy, 0, 0, 1, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [21:0] f_id();
        return o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [21:0] f_exe(int sb, int aop);
        return o(2, 0, 0, 0, 0, 0, 1, sb, aop, 0, 0, 0, 0);
    endfunction

    function automatic logic [21:0] f_wb(int rdst, int wd);
        return o(4, 0, 0, 0, 0, 1, 0, 0, 0, rdst, wd, 0, 0);
    endfunction

    task automatic step(input string tag, input int op_i, input int fn_i,
                        input int zf_i, input int rdy_i, input int rst_i,
                        input logic [21:0] exp);
        logic [21:0] got;
        op      = op_i[5:0];
        funct   = fn_i[5:0];
        zf      = zf_i[0];
        mem_rdy = rdy_i[0];
        rst     = rst_i[0];
        #1;
        got = {state, mem_req, mem_wr, pc_wr, ir_wr, reg_wr, alu_src_a,
               alu_src_b, alu_op, reg_dst, wd_sel, npc_op, illegal};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        op      = 6'h00;
        funct   = 6'h00;
        zf      = 1'b0;
        mem_rdy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset holds S_IF with every enable and the request suppressed.
        step("rst_hold", 6'h3f, 6'h3f, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        // addu: 0,1,2,4 then back to fetch; opcode garbage in IF is ignored.
        step("addu_if",  6'h3f, 6'h3f, 0, 1, 0, f_if(1));
        step("addu_id",  6'h00, 6'h21, 0, 1, 0, f_id());
        step("addu_exe", 6'h00, 6'h21, 0, 1, 0, f_exe(0, 0));
        step("addu_wb",  6'h00, 6'h21, 0, 1, 0, f_wb(1, 0));

        // lw with 2 fetch waits and 3 memory waits: 10 cycles.
        step("lw_if_w0", 6'h00, 6'h00, 0, 0, 0, f_if(0));
        step("lw_if_w1", 6'h00, 6'h00, 0, 0, 0, f_if(0));
        step("lw_if",    6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("lw_id",    6'h23, 6'h00, 0, 1, 0, f_id());
        step("lw_exe",   6'h23, 6'h00, 0, 1, 0, f_exe(2, 0));
        step("lw_mem_w0", 6'h23, 6'h00, 0, 0, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("lw_mem_w1", 6'h23, 6'h00, 0, 0, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("lw_mem_w2", 6'h23, 6'h00, 0, 0, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("lw_mem",   6'h23, 6'h00, 0, 1, 0, o(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("lw_wb",    6'h23, 6'h00, 0, 1, 0, f_wb(0, 1));

        // beq taken, then not taken.
        step("beq1_if",  6'h00, 6'h00, 1, 1, 0, f_if(1));
        step("beq1_id",  6'h04, 6'h00, 1, 1, 0, f_id());
        step("beq1_exe", 6'h04, 6'h00, 1, 1, 0, o(2, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0));
        step("beq0_if",  6'h04, 6'h00, 1, 1, 0, f_if(1));
        step("beq0_id",  6'h04, 6'h00, 0, 1, 0, f_id());
        step("beq0_exe", 6'h04, 6'h00, 0, 1, 0, o(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));

        // jal and j: two cycles each.
        step("jal_if", 6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("jal_id", 6'h03, 6'h00, 0, 1, 0, o(1, 0, 0, 1, 0, 1, 0, 0, 0, 2, 2, 2, 0));
        step("j_if",   6'h03, 6'h00, 0, 1, 0, f_if(1));
        step("j_id",   6'h02, 6'h00, 0, 1, 0, o(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0));

        // Unsupported opcode, then unsupported R-type funct.
        step("ill_op_if", 6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("ill_op_id", 6'h3f, 6'h00, 0, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("ill_fn_if", 6'h3f, 6'h00, 0, 1, 0, f_if(1));
        step("ill_fn_id", 6'h00, 6'h01, 0, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // I-type and R-type ALU op selection.
        step("addi_if",  6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("addi_id",  6'h08, 6'h00, 0, 1, 0, f_id());
        step("addi_exe", 6'h08, 6'h00, 0, 1, 0, f_exe(2, 11));
        step("addi_wb",  6'h08, 6'h00, 0, 1, 0, f_wb(0, 0));
        step("andi_if",  6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("andi_id",  6'h0c, 6'h00, 0, 1, 0, f_id());
        step("andi_exe", 6'h0c, 6'h00, 0, 1, 0, f_exe(3, 5));
        step("andi_wb",  6'h0c, 6'h00, 0, 1, 0, f_wb(0, 0));
        step("ori_if",   6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("ori_id",   6'h0d, 6'h00, 0, 1, 0, f_id());
        step("ori_exe",  6'h0d, 6'h00, 0, 1, 0, f_exe(3, 2));
        step("ori_wb",   6'h0d, 6'h00, 0, 1, 0, f_wb(0, 0));
        step("slt_if",   6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("slt_id",   6'h00, 6'h2a, 0, 1, 0, f_id());
        step("slt_exe",  6'h00, 6'h2a, 0, 1, 0, f_exe(0, 9));
        step("slt_wb",   6'h00, 6'h2a, 0, 1, 0, f_wb(1, 0));
        step("nor_if",   6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("nor_id",   6'h00, 6'h27, 0, 1, 0, f_id());
        step("nor_exe",  6'h00, 6'h27, 0, 1, 0, f_exe(0, 8));
        step("nor_wb",   6'h00, 6'h27, 0, 1, 0, f_wb(1, 0));

        // sw completing normally: 4 cycles.
        step("sw_if",  6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("sw_id",  6'h2b, 6'h00, 0, 1, 0, f_id());
        step("sw_exe", 6'h2b, 6'h00, 0, 1, 0, f_exe(2, 0));
        step("sw_mem", 6'h2b, 6'h00, 0, 1, 0, o(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // sw aborted by reset during a memory wait.
        step("swr_if",    6'h00, 6'h00, 0, 1, 0, f_if(1));
        step("swr_id",    6'h2b, 6'h00, 0, 1, 0, f_id());
        step("swr_exe",   6'h2b, 6'h00, 0, 1, 0, f_exe(2, 0));
        step("swr_mem_w", 6'h2b, 6'h00, 0, 0, 0, o(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("swr_rst",   6'h2b, 6'h00, 0, 0, 1, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("swr_after", 6'h2b, 6'h00, 0, 1, 0, f_if(1));
        step("swr_next",  6'h00, 6'h21, 0, 1, 0, f_id());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
